// File: rtl/idct16_seq.sv
// idct16_seq: two-pass sequencer for a 16-point IDCT datapath.
// Ports: clk/rst, start/abort control, in_valid/in_ready/load
// input handshake, out_valid/out_ready/out_last output handshake,
// row_idx/pass/shift datapath controls, busy/done status.
module idct16_seq #(
  parameter int LAT  = 3,
  parameter int ROWS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] row_idx,
  output logic       pass,
  output logic [3:0] shift,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
  localparam bit         HAS_WAIT = (LAT > 1);
  localparam logic [3:0] SHIFT_ROW = 4'd7;
  localparam logic [3:0] SHIFT_COL = 4'd12;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] r_row;
  logic [3:0] w_row_nxt;
  logic       r_pass;
  logic       w_pass_nxt;
  logic [3:0] r_shift;
  logic       r_done;
  logic       w_done_nxt;
  logic       w_in_hs;
  logic       w_out_hs;
  logic       w_row_last;

  assign in_ready   = (r_state == S_ACCEPT);
  assign load       = in_valid & in_ready;
  assign out_valid  = (r_state == S_OUT);
  assign w_row_last = (r_row == ROW_LAST);
  assign out_last   = out_valid & w_row_last;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign row_idx    = r_row;
  assign pass       = r_pass;
  assign shift      = r_shift;

  assign w_in_hs  = load;
  assign w_out_hs = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    w_pass_nxt  = r_pass;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_row_nxt   = 4'd0;
          w_pass_nxt  = 1'b0;
          w_state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (w_in_hs) begin
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = HAS_WAIT ? S_WAIT : S_OUT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        // <=1 keeps a stray zero count from spinning through a wrap
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (w_out_hs) begin
          if (!w_row_last) begin
            w_row_nxt   = r_row + 4'd1;
            w_state_nxt = S_ACCEPT;
          end else if (!r_pass) begin
            w_row_nxt   = 4'd0;
            w_pass_nxt  = 1'b1;
            w_state_nxt = S_ACCEPT;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // abort overrides every other transition, including completion
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
      w_row_nxt   = 4'd0;
      w_pass_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_row   <= 4'd0;
      r_pass  <= 1'b0;
      r_shift <= SHIFT_ROW;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
      r_pass  <= w_pass_nxt;
      // shift tracks pass from a register so it never glitches
      r_shift <= w_pass_nxt ? SHIFT_COL : SHIFT_ROW;
      r_done  <= w_done_nxt;
    end
  end

endmodule
